cpu_pio_in_edge: RTL

//  Parametrised Avalon-MM input PIO; successor to the fixed 2-bit registered input port.

---
 rtl/cpu_pio_pkg.sv | 24 ++
 rtl/cpu_pio_debounce_bit.sv | 67 ++++++
 rtl/cpu_pio_in_edge.sv | 117 +++++++++++
 3 files changed

// File: rtl/cpu_pio_pkg.sv
// Shared register map, edge encodings and small helpers for the CPU PIO input port family.
package cpu_pio_pkg;

   localparam int DATA_W = 32;

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_RSVD    = 2'd1;
   localparam logic [1:0] ADDR_IRQMASK = 2'd2;
   localparam logic [1:0] ADDR_EDGECAP = 2'd3;

   localparam int EDGE_RISE = 0;
   localparam int EDGE_FALL = 1;
   localparam int EDGE_ANY  = 2;

   typedef enum logic {
      ARM_WAIT  = 1'b0,
      ARM_READY = 1'b1
   } arm_state_e;

   function automatic int cnt_width(input int max_count);
      return $clog2(max_count + 1);
   endfunction

endpackage

// File: rtl/cpu_pio_debounce_bit.sv
// One input bit: synchroniser chain plus, when CPU_PIO_DEBOUNCE_EN is defined,
// a stability filter that only passes a level held for DEBOUNCE_CYCLES cycles.
module cpu_pio_debounce_bit
   import cpu_pio_pkg::*;
#(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic reset,
   input  logic i_in,
   output logic o_data
);

   logic [SYNC_STAGES-1:0] r_sync;
   logic                   w_s;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_sync <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], i_in};
      end
   end

   assign w_s = r_sync[SYNC_STAGES-1];

`ifdef CPU_PIO_DEBOUNCE_EN
   localparam int              CW    = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   C_MAX = CW'(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]   C_HIT = CW'(DEBOUNCE_CYCLES - 2);

   logic          r_s_prev;
   logic [CW-1:0] r_cnt;
   logic          r_f;
   logic          w_stable;

   assign w_stable = (w_s == r_s_prev);

   // The cycle in which s first shows a new level counts as the first stable
   // cycle, so the filter output follows exactly DEBOUNCE_CYCLES cycles later.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_s_prev <= 1'b0;
         r_cnt    <= '0;
         r_f      <= 1'b0;
      end else begin
         r_s_prev <= w_s;
         if (!w_stable) begin
            r_cnt <= '0;
         end else begin
            if (r_cnt != C_MAX) begin
               r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt >= C_HIT) begin
               r_f <= w_s;
            end
         end
      end
   end

   assign o_data = r_f;
`else
   assign o_data = w_s;
`endif

endmodule

// File: rtl/cpu_pio_in_edge.sv
// Avalon-MM input PIO with per-bit sticky edge capture and a maskable level irq.
// Optional per-bit debounce filter is built when CPU_PIO_DEBOUNCE_EN is defined.
module cpu_pio_in_edge
   import cpu_pio_pkg::*;
#(
   parameter int WIDTH           = 2,
   parameter int SYNC_STAGES     = 2,
   parameter int EDGE_TYPE       = EDGE_RISE,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [1:0]        address,
   input  logic              write,
   input  logic [31:0]       writedata,
   output logic [31:0]       readdata,
   input  logic [WIDTH-1:0]  in_port,
   output logic              irq
);

   localparam int              ACW      = cnt_width(SYNC_STAGES);
   localparam logic [ACW-1:0]  ARM_LAST = ACW'(SYNC_STAGES);

   logic [WIDTH-1:0]  w_data;
   logic [WIDTH-1:0]  r_prev;
   logic [WIDTH-1:0]  w_det;
   logic [WIDTH-1:0]  w_clear;
   logic [WIDTH-1:0]  r_edgecap;
   logic [WIDTH-1:0]  r_irqmask;
   logic [DATA_W-1:0] w_rd_mux;
   logic [DATA_W-1:0] r_readdata;
   logic              r_irq;
   arm_state_e        r_arm_state;
   logic [ACW-1:0]    r_arm_cnt;
   logic              w_armed;
   logic              w_unused_wdata;

   for (genvar g = 0; g < WIDTH; g++) begin : g_bit
      cpu_pio_debounce_bit #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_bit (
         .clk    (clk),
         .reset  (reset),
         .i_in   (in_port[g]),
         .o_data (w_data[g])
      );
   end

   // Hold off edge detection until the synchronisers have flushed, so inputs
   // already high at reset release do not register as rising edges.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_arm_state <= ARM_WAIT;
         r_arm_cnt   <= '0;
      end else if (r_arm_state == ARM_WAIT) begin
         if (r_arm_cnt == ARM_LAST) begin
            r_arm_state <= ARM_READY;
         end else begin
            r_arm_cnt <= r_arm_cnt + 1'b1;
         end
      end
   end

   assign w_armed = (r_arm_state == ARM_READY);

   always_comb begin
      w_det = '0;
      case (EDGE_TYPE)
         EDGE_FALL: w_det = ~w_data & r_prev;
         EDGE_ANY:  w_det = w_data ^ r_prev;
         default:   w_det = w_data & ~r_prev;
      endcase
   end

   assign w_clear        = {WIDTH{write && (address == ADDR_EDGECAP)}} & writedata[WIDTH-1:0];
   assign w_unused_wdata = ^writedata;

   // A detect wins over a same-cycle write-1-to-clear on that bit.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_prev    <= '0;
         r_edgecap <= '0;
         r_irqmask <= '0;
         r_irq     <= 1'b0;
      end else begin
         r_prev    <= w_data;
         r_edgecap <= (w_det & {WIDTH{w_armed}}) | (r_edgecap & ~w_clear);
         if (write && (address == ADDR_IRQMASK)) begin
            r_irqmask <= writedata[WIDTH-1:0];
         end
         r_irq <= |(r_edgecap & r_irqmask);
      end
   end

   always_comb begin
      w_rd_mux = '0;
      case (address)
         ADDR_DATA:    w_rd_mux[WIDTH-1:0] = w_data;
         ADDR_IRQMASK: w_rd_mux[WIDTH-1:0] = r_irqmask;
         ADDR_EDGECAP: w_rd_mux[WIDTH-1:0] = r_edgecap;
         default:      w_rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_readdata <= '0;
      end else begin
         r_readdata <= w_rd_mux;
      end
   end

   assign readdata = r_readdata;
   assign irq      = r_irq;

endmodule
